// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch port: the fetch controller drives req/addr, memory answers with ack/rdata.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control for the rv32i core: next-PC select, imem fetch handshake,
// instret counting and halt on a misaligned taken target.
//
// state | meaning
// BOOT  | one idle cycle after reset
// FETCH | imem_req held with imem_addr=pc until imem_ack
// EXEC  | inst valid for decode, waiting for retire
// TRAP  | misaligned control transfer; frozen until rst
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 next_pc_src,
    input  logic [31:0]          alu_res,
    input  logic                 retire,
    pc_fetch_ctrl_if.master      imem,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 misaligned,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] target;
    logic        fetch_done;
    logic        commit;
    logic        fault;

    assign pc_plus4   = pc + 32'd4;
    // Bit 0 of a taken target is dropped (JALR); bit 1 is what faults.
    assign target     = next_pc_src ? {alu_res[31:1], 1'b0} : pc_plus4;
    assign fetch_done = (state == FETCH) && imem.imem_ack;
    assign commit     = (state == EXEC) && retire && !target[1];
    assign fault      = (state == EXEC) && retire &&  target[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (fetch_done) state_nxt = EXEC;
            EXEC: begin
                if (commit)     state_nxt = FETCH;
                else if (fault) state_nxt = TRAP;
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state == FETCH);
        imem.imem_addr = pc;
        inst_valid     = (state == EXEC);
        halted         = (state == TRAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst       <= NOP;
            misaligned <= 1'b0;
            instret    <= '0;
        end else begin
            if (fetch_done) begin
                inst <= imem.imem_rdata;
            end
            if (commit) begin
                pc      <= target;
                instret <= instret + INSTRET_W'(1);
            end
            if (fault) begin
                misaligned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: the sequence pushes expected fetches/instructions,
// a negedge monitor pops and compares them as the DUT raises imem_req / inst_valid.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_pc_src;
    logic [31:0] alu_res;
    logic        retire;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        halted;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] instret;
    } fexp_t;

    fexp_t       fq[$];
    logic [31:0] iq[$];

    pc_fetch_ctrl_if imem ();

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .INSTRET_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc_src(next_pc_src),
        .alu_res    (alu_res),
        .retire     (retire),
        .imem       (imem.master),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned),
        .halted     (halted),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT-presented fetches and instructions against queued expectations.
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] cur_addr   = '0;

    always @(negedge clk) begin
        if (imem.imem_req && !prev_req) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got addr %h expected no fetch", imem.imem_addr);
                cur_addr = imem.imem_addr;
            end else begin
                fexp_t e;
                e = fq.pop_front();
                cur_addr = e.addr;
                chk("fetch_addr", {32'h0, imem.imem_addr}, {32'h0, e.addr});
                chk("fetch_pc_plus4", {32'h0, pc_plus4}, {32'h0, e.addr + 32'd4});
                chk("fetch_instret", instret, e.instret);
                chk("fetch_misaligned", {63'h0, misaligned}, 64'h0);
            end
        end else if (imem.imem_req) begin
            chk("addr_stable", {32'h0, imem.imem_addr}, {32'h0, cur_addr});
        end
        if (inst_valid && !prev_valid) begin
            if (iq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got %h expected none", inst);
            end else begin
                logic [31:0] ei;
                ei = iq.pop_front();
                chk("inst", {32'h0, inst}, {32'h0, ei});
                chk("inst_req_low", {63'h0, imem.imem_req}, 64'h0);
            end
        end
        prev_req   = imem.imem_req;
        prev_valid = inst_valid;
    end

    task automatic do_fetch(input logic [31:0] data, input int delay);
        int n = 0;
        @(negedge clk);
        while (!imem.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem.imem_req) begin
            chk("fetch_req_timeout", {63'h0, imem.imem_req}, 64'h1);
        end else begin
            repeat (delay) @(negedge clk);
            imem.imem_ack   = 1'b1;
            imem.imem_rdata = data;
            @(negedge clk);
            imem.imem_ack   = 1'b0;
        end
    endtask

    task automatic do_retire(input logic src, input logic [31:0] alu);
        int n = 0;
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!inst_valid) begin
            chk("retire_valid_timeout", {63'h0, inst_valid}, 64'h1);
        end else begin
            next_pc_src = src;
            alu_res     = alu;
            retire      = 1'b1;
            @(negedge clk);
            retire      = 1'b0;
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [63:0] n);
        fexp_t e;
        e.addr    = a;
        e.instret = n;
        fq.push_back(e);
    endtask

    initial begin
        rst             = 1'b1;
        next_pc_src     = 1'b0;
        alu_res         = '0;
        retire          = 1'b0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", {32'h0, pc}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h13);
        chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_req", {63'h0, imem.imem_req}, 64'h0);
        chk("rst_misaligned", {63'h0, misaligned}, 64'h0);
        chk("rst_halted", {63'h0, halted}, 64'h0);
        chk("rst_instret", instret, 64'h0);

        // Test 1: ack on the second FETCH cycle
        push_fetch(32'h0, 64'd0);
        iq.push_back(32'h00A0_0093);
        rst = 1'b0;
        do_fetch(32'h00A0_0093, 1);

        // Test 2: fall-through retire
        push_fetch(32'h4, 64'd1);
        do_retire(1'b0, 32'h0);
        chk("t2_pc", {32'h0, pc}, 64'h4);
        chk("t2_instret", instret, 64'd1);
        iq.push_back(32'h0000_0113);
        do_fetch(32'h0000_0113, 0);

        push_fetch(32'h10, 64'd2);
        do_retire(1'b1, 32'h0000_0010);
        iq.push_back(32'h0000_0193);
        do_fetch(32'h0000_0193, 0);

        // Test 3: bit 0 of the taken target is cleared
        push_fetch(32'h40, 64'd3);
        do_retire(1'b1, 32'h0000_0041);
        chk("t3_pc", {32'h0, pc}, 64'h40);
        iq.push_back(32'h0000_0213);
        do_fetch(32'h0000_0213, 2);

        // Test 5: pc+4 wraps from the top of the address space
        push_fetch(32'hFFFF_FFFC, 64'd4);
        do_retire(1'b1, 32'hFFFF_FFFD);
        iq.push_back(32'h0000_0293);
        do_fetch(32'h0000_0293, 0);
        push_fetch(32'h0, 64'd5);
        do_retire(1'b0, 32'h1234_5678);
        chk("t5_pc", {32'h0, pc}, 64'h0);
        chk("t5_misaligned", {63'h0, misaligned}, 64'h0);
        iq.push_back(32'h0000_0313);
        do_fetch(32'h0000_0313, 0);

        push_fetch(32'h10, 64'd6);
        do_retire(1'b1, 32'h0000_0010);
        iq.push_back(32'h0000_0393);
        do_fetch(32'h0000_0393, 0);

        // Test 4: misaligned taken target traps
        do_retire(1'b1, 32'h0000_0022);
        chk("t4_misaligned", {63'h0, misaligned}, 64'h1);
        chk("t4_halted", {63'h0, halted}, 64'h1);
        chk("t4_pc", {32'h0, pc}, 64'h10);
        chk("t4_instret", instret, 64'd6);
        chk("t4_inst_valid", {63'h0, inst_valid}, 64'h0);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'hFFFF_FFFF;
        retire          = 1'b1;
        next_pc_src     = 1'b0;
        repeat (3) @(negedge clk);
        imem.imem_ack = 1'b0;
        retire        = 1'b0;
        chk("t4_frozen_pc", {32'h0, pc}, 64'h10);
        chk("t4_frozen_inst", {32'h0, inst}, 64'h0000_0393);
        chk("t4_frozen_instret", instret, 64'd6);
        chk("t4_frozen_req", {63'h0, imem.imem_req}, 64'h0);
        chk("t4_frozen_halted", {63'h0, halted}, 64'h1);

        // Test 6: reset lands on the same edge as an ack
        rst = 1'b1;
        @(negedge clk);
        push_fetch(32'h0, 64'd0);
        rst = 1'b0;
        begin
            int n = 0;
            while (!imem.imem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_req_seen", {63'h0, imem.imem_req}, 64'h1);
        end
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'hDEAD_BEEF;
        rst             = 1'b1;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        chk("t6_pc", {32'h0, pc}, 64'h0);
        chk("t6_inst", {32'h0, inst}, 64'h13);
        chk("t6_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("t6_instret", instret, 64'd0);
        chk("t6_misaligned", {63'h0, misaligned}, 64'h0);
        chk("t6_halted", {63'h0, halted}, 64'h0);

        push_fetch(32'h0, 64'd0);
        iq.push_back(32'h0010_0113);
        rst = 1'b0;
        do_fetch(32'h0010_0113, 0);
        push_fetch(32'h4, 64'd1);
        do_retire(1'b0, 32'h0);
        repeat (3) @(negedge clk);

        chk("fetch_queue_drained", 64'(fq.size()), 64'd0);
        chk("inst_queue_drained", 64'(iq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
